// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator for the program ROM. It owns the fetch PC and buffers fetched
// {pc, instruction} pairs in a small queue that feeds decode over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instruction,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic              full, pop, push;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = instr_valid & instr_ready & ~redirect;
    // A pop frees the head slot in the same cycle, so a full queue can still accept a push.
    assign push = ~halt & ~redirect & (~full | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_target;
            rd_d       = '0;
            wr_d       = '0;
            count_d    = '0;
        end else begin
            if (pop)
                rd_d = rd_q + PTR_W'(1);
            if (push) begin
                wr_d       = wr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            if (push) begin
                data_q[wr_q] <= instruction;
                addr_q[wr_q] <= fetch_pc_q;
            end
        end
    end

    // Head outputs come only from registered state and are gated to zero when empty.
    assign pc          = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? data_q[rd_q] : '0;
    assign instr_pc    = instr_valid ? addr_q[rd_q] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: hand-derived vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_instruction_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic       halt = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       instr_ready = 1'b0;

    logic [7:0] rom_mem [256];
    assign instruction = rom_mem[pc];

    instruction_fetch_unit #(.ADDR_W(8), .DATA_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction), .halt(halt),
        .redirect(redirect), .redirect_target(redirect_target), .instr_valid(instr_valid),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a FIFO of {address, data} pairs plus an integer fetch PC.
    typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;
    ent_t mq[$];
    int   mpc;
    localparam int DEPTH = 2;

    typedef struct {
        logic       h, r, rdy;
        logic [7:0] tgt;
        logic       ev;
        logic [7:0] eipc, epc;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_obs();
        logic [31:0] o;
        if (mq.size() > 0) o = {8'h01, mq[0].d, mq[0].a, 8'(mpc)};
        else               o = {8'h00, 8'h00, 8'h00, 8'(mpc)};
        return o;
    endfunction

    function automatic logic [31:0] dut_obs();
        return {7'b0, instr_valid, instr_data, instr_pc, pc};
    endfunction

    // Entered just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic h, input logic r, input logic [7:0] t, input logic rdy,
                        output logic [31:0] obs);
        bit p, q;
        halt = h; redirect = r; redirect_target = t; instr_ready = rdy;
        #1;
        obs = dut_obs();
        check("model", obs, model_obs());
        p = (mq.size() > 0) && rdy && !r;
        q = !h && !r && (mq.size() < DEPTH || p);
        @(posedge clk);
        if (r) begin
            mq.delete();
            mpc = t;
        end else begin
            if (p) void'(mq.pop_front());
            if (q) begin
                mq.push_back('{a: 8'(mpc), d: rom_mem[mpc]});
                mpc = (mpc + 1) % 256;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", dut_obs(), 32'h0);
        mq.delete();
        mpc = 0;
        halt = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[13];
    logic [31:0] o;
    logic [7:0]  held;

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
        rom_mem[0] = 8'h39;
        mpc = 0;

        tbl[0]  = '{h:0, r:0, rdy:1, tgt:8'h00, ev:0, eipc:8'h00, epc:8'h00};
        tbl[1]  = '{h:0, r:0, rdy:1, tgt:8'h00, ev:1, eipc:8'h00, epc:8'h01};
        tbl[2]  = '{h:0, r:0, rdy:0, tgt:8'h00, ev:1, eipc:8'h01, epc:8'h02};
        tbl[3]  = '{h:0, r:0, rdy:0, tgt:8'h00, ev:1, eipc:8'h01, epc:8'h03};
        tbl[4]  = '{h:0, r:0, rdy:0, tgt:8'h00, ev:1, eipc:8'h01, epc:8'h03};
        tbl[5]  = '{h:0, r:1, rdy:1, tgt:8'h40, ev:1, eipc:8'h01, epc:8'h03};
        tbl[6]  = '{h:0, r:0, rdy:1, tgt:8'h00, ev:0, eipc:8'h00, epc:8'h40};
        tbl[7]  = '{h:0, r:0, rdy:1, tgt:8'h00, ev:1, eipc:8'h40, epc:8'h41};
        tbl[8]  = '{h:1, r:0, rdy:0, tgt:8'h00, ev:1, eipc:8'h41, epc:8'h42};
        tbl[9]  = '{h:1, r:0, rdy:1, tgt:8'h00, ev:1, eipc:8'h41, epc:8'h42};
        tbl[10] = '{h:1, r:0, rdy:1, tgt:8'h00, ev:0, eipc:8'h00, epc:8'h42};
        tbl[11] = '{h:0, r:0, rdy:1, tgt:8'h00, ev:0, eipc:8'h00, epc:8'h42};
        tbl[12] = '{h:0, r:0, rdy:1, tgt:8'h00, ev:1, eipc:8'h42, epc:8'h43};

        @(negedge clk);
        check("reset_state", dut_obs(), 32'h0);
        rst_n = 1'b1;

        // Hand-derived vector table
        foreach (tbl[i]) begin
            step(tbl[i].h, tbl[i].r, tbl[i].tgt, tbl[i].rdy, o);
            check($sformatf("vec%0d", i), o,
                  {7'b0, tbl[i].ev, (tbl[i].ev ? rom_mem[tbl[i].eipc] : 8'h00),
                   tbl[i].eipc, tbl[i].epc});
        end

        // Async reset mid-stream, then first instruction one edge after release
        do_reset();
        step(0, 0, 8'h00, 0, o);
        check("post_reset_empty", o, 32'h0000_0000);
        step(0, 0, 8'h00, 1, o);
        check("first_instr", o[23:0], {8'h39, 8'h00, 8'h01});
        check("first_valid", {31'b0, o[24]}, 32'h1);

        // Streaming: consecutive addresses, one per clock
        for (int i = 1; i < 20; i++) begin
            step(0, 0, 8'h00, 1, o);
            check("stream", o[24:8], {1'b1, rom_mem[i], 8'(i)});
        end

        // Backpressure from reset: pc holds at 02 while full, then drains in order
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, o);
        check("full_pc_hold", {24'b0, o[7:0]}, 32'h02);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 1, o);
            check("drain", {24'b0, o[15:8]}, 32'(i));
        end

        // Redirect while full with ready: head kept, then empty at target, then target valid
        for (int i = 0; i < 2; i++) step(0, 0, 8'h00, 0, o);
        step(0, 1, 8'h40, 1, o);
        step(0, 0, 8'h00, 1, o);
        check("redir_empty", o, {8'h00, 8'h00, 8'h00, 8'h40});
        step(0, 0, 8'h00, 1, o);
        check("redir_target", o[24:8], {1'b1, rom_mem[8'h40], 8'h40});

        // Address wrap FE, FF, 00, 01
        step(0, 1, 8'hFE, 1, o);
        step(0, 0, 8'h00, 1, o);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 1, o);
            check("wrap", {24'b0, o[15:8]}, 32'((8'hFE + i) % 256));
        end

        // Halt with two queued: two pops, then empty with pc frozen, then resume
        for (int i = 0; i < 2; i++) step(0, 0, 8'h00, 0, o);
        held = pc;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 1, o);
            check("halt_pc", {24'b0, o[7:0]}, {24'b0, held});
            check("halt_valid", {31'b0, o[24]}, {31'b0, (i < 2)});
        end
        step(0, 0, 8'h00, 1, o);
        step(0, 0, 8'h00, 1, o);
        check("resume", o[24:8], {1'b1, rom_mem[held], held});

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
                 8'($urandom), ($urandom_range(0, 9) < 6), o);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
